coef_loader: RTL

Serial coefficient loader for the FIR datapath. Accepts `NCOEF` parallel coefficients over a valid/ready handshake and serialises them onto the datapath's coefficient shift chain. It drives `shiftIn` with non-overlapping `shiftClk1`/`shiftClk2` strobes, all generated from one system clock. It sits between the control/host interface and the datapath and is the transmit end of the coefficient shift-chain interface.

---
 rtl/coef_loader_if.sv | 11 +
 rtl/coef_loader.sv | 122 ++++++++++++
 2 files changed

// File: rtl/coef_loader_if.sv
// Host-side coefficient handshake: master drives data/valid, the loader (slave) returns ready.
interface coef_loader_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] coefIn;
  logic             coefValid;
  logic             coefReady;

  modport master (output coefIn, output coefValid, input coefReady);
  modport slave  (input coefIn, input coefValid, output coefReady);
endinterface

// File: rtl/coef_loader.sv
// Serialises NCOEF parallel coefficients, MSB first, onto the FIR coefficient shift chain
// using four-phase bit slots with non-overlapping shiftClk1/shiftClk2 strobes.
module coef_loader #(
  parameter int WIDTH = 8,
  parameter int NCOEF = 4
) (
  input  logic            ph1,
  input  logic            reset,
  input  logic            start,
  coef_loader_if.slave    host,
  output logic            shiftIn,
  output logic            shiftClk1,
  output logic            shiftClk2,
  output logic            loading,
  output logic            done
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(NCOEF) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NCOEF);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             coef_ready_q, coef_ready_d;
  logic             shift_in_q, shift_in_d;
  logic             clk1_q, clk1_d;
  logic             clk2_q, clk2_d;
  logic             loading_q, loading_d;
  logic             done_q, done_d;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;

    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        bit_d   = '0;
        cnt_d   = '0;
        if (start) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (host.coefValid && coef_ready_q) begin
          sreg_d  = host.coefIn;
          cnt_d   = cnt_q + 1'b1;
          phase_d = '0;
          bit_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          sreg_d = sreg_q << 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (cnt_q < CNT_FULL) ? S_WAIT : S_DONE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from next state so they leave flops aligned with the state they describe.
    coef_ready_d = (state_d == S_WAIT);
    loading_d    = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    clk1_d       = (state_d == S_SHIFT) && (phase_d == 2'd1);
    clk2_d       = (state_d == S_SHIFT) && (phase_d == 2'd3);
    shift_in_d   = (state_d == S_SHIFT) ? sreg_d[WIDTH-1] : shift_in_q;
  end

  always_ff @(posedge ph1) begin
    // NOTE: non-blocking assignments so every flop samples the values from before this edge.
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      bit_q        <= '0;
      cnt_q        <= '0;
      coef_ready_q <= 1'b0;
      shift_in_q   <= 1'b0;
      clk1_q       <= 1'b0;
      clk2_q       <= 1'b0;
      loading_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      cnt_q        <= cnt_d;
      coef_ready_q <= coef_ready_d;
      shift_in_q   <= shift_in_d;
      clk1_q       <= clk1_d;
      clk2_q       <= clk2_d;
      loading_q    <= loading_d;
      done_q       <= done_d;
    end
  end

  // NOTE: the data register has no reset; it is always loaded on accept before any bit leaves it.
  always_ff @(posedge ph1) begin
    sreg_q <= sreg_d;
  end

  assign host.coefReady = coef_ready_q;
  assign shiftIn        = shift_in_q;
  assign shiftClk1      = clk1_q;
  assign shiftClk2      = clk2_q;
  assign loading        = loading_q;
  assign done           = done_q;
endmodule
